// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared widths, timeout limit and the fetch FSM state type for the CPU
// front end. Imported by fetch_unit and pc_counter.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W          = 13;  // program counter / word address width
    localparam int INSTR_W       = 16;  // instruction word width
    localparam int OPCODE_W      = 4;   // opcode field width, ir[15:12]
    localparam int FETCH_TIMEOUT = 15;  // READ cycles without ack before ERR
    localparam int WAIT_W        = 4;   // wait counter width, holds 0..FETCH_TIMEOUT

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
// Program counter register with parallel load and increment. Load has
// priority over increment; the increment wraps modulo 2^PC_W.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, clears pc to 0
//   load     in   load load_val into pc
//   load_val in   PC_W-bit value to load
//   inc      in   increment pc by one (ignored when load is set)
//   pc       out  current program counter
// ---------------------------------------------------------------------------
module pc_counter
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule : pc_counter

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer. On a fetch request it reads the word at pc
// from instruction memory, holds the read until acknowledged, captures the
// word into ir and advances pc. Jumps load pc directly when idle, or are
// parked in a one-entry pending register while a fetch is in flight and
// applied on the way back to IDLE. A read left unacknowledged for
// FETCH_TIMEOUT cycles parks the unit in ERR until reset.
//
// Ports
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   fetch_req    request to fetch the next instruction (pulse)
//   fetch_done   one-cycle pulse, ir/opcode hold the new instruction
//   fetch_busy   high while a fetch is in flight (READ, DONE)
//   jump_en      load pc from jump_target (pulse)
//   jump_target  jump destination word address
//   mem_addr     instruction memory word address (== pc)
//   mem_rd       memory read strobe, high only in READ
//   mem_ack      read complete, mem_rdata valid in the same cycle
//   mem_rdata    memory read data
//   ir, opcode   instruction register and its top field
//   pc           address of the next fetch
//   fetch_err    sticky timeout flag
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req,
    output logic                fetch_done,
    output logic                fetch_busy,
    input  logic                jump_en,
    input  logic [PC_W-1:0]     jump_target,
    output logic [PC_W-1:0]     mem_addr,
    output logic                mem_rd,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0]  ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     pc,
    output logic                fetch_err
);

    fetch_state_t      state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              pend_valid;
    logic [PC_W-1:0]   pend_target;

    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    logic              pc_inc;
    logic              ir_load;

    pc_counter u_pc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        pc_load_val = jump_target;
        pc_inc      = 1'b0;
        ir_load     = 1'b0;

        unique case (state)
            IDLE: begin
                // A jump issued with the request lands in pc before READ,
                // so the fetch addresses the target and then increments it.
                if (jump_en) begin
                    pc_load = 1'b1;
                end
                if (fetch_req) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = DONE;
                end else if (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1)) begin
                    next_state = ERR;
                end
            end
            DONE: begin
                // A jump arriving in this very cycle is newer than anything
                // pending, so it wins.
                next_state = IDLE;
                if (jump_en) begin
                    pc_load = 1'b1;
                end else if (pend_valid) begin
                    pc_load     = 1'b1;
                    pc_load_val = pend_target;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: ir, the wait counter and the pending jump are all cleared by
    // rst; none of them is large enough to be worth leaving unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            ir          <= '0;
        end else begin
            if (state == READ && !mem_ack) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (state == DONE) begin
                pend_valid <= 1'b0;
            end else if (state == READ && jump_en) begin
                pend_valid  <= 1'b1;
                pend_target <= jump_target;
            end

            if (ir_load) begin
                ir <= mem_rdata;
            end
        end
    end

    assign mem_addr   = pc;
    assign mem_rd     = (state == READ);
    assign fetch_busy = (state == READ) || (state == DONE);
    assign fetch_done = (state == DONE);
    assign fetch_err  = (state == ERR);   // sticky: ERR is left only by rst
    assign opcode     = ir[INSTR_W-1 -: OPCODE_W];

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Inputs change and outputs are sampled
// on the falling clock edge. A table of fetch vectors runs back to back from
// reset, followed by hand-written sequences for jumps in flight, ignored
// requests/acks, timeout and reset mid-read.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import cpu_pkg::*;

    logic                clk;
    logic                rst;
    logic                fetch_req;
    logic                fetch_done;
    logic                fetch_busy;
    logic                jump_en;
    logic [PC_W-1:0]     jump_target;
    logic [PC_W-1:0]     mem_addr;
    logic                mem_rd;
    logic                mem_ack;
    logic [INSTR_W-1:0]  mem_rdata;
    logic [INSTR_W-1:0]  ir;
    logic [OPCODE_W-1:0] opcode;
    logic [PC_W-1:0]     pc;
    logic                fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_done  (fetch_done),
        .fetch_busy  (fetch_busy),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .opcode      (opcode),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                jmp;
        logic [PC_W-1:0]     target;
        logic [INSTR_W-1:0]  rdata;
        int                  delay;     // ack arrives in this READ cycle (1 = first)
        logic [PC_W-1:0]     exp_addr;
        logic [OPCODE_W-1:0] exp_op;
        logic [PC_W-1:0]     exp_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        fetch_req   = 1'b1;
        jump_en     = v.jmp;
        jump_target = v.target;
        @(negedge clk);
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        for (int k = 1; k <= v.delay; k++) begin
            check($sformatf("v%0d mem_rd c%0d", idx, k), 32'(mem_rd), 32'd1);
            check($sformatf("v%0d mem_addr c%0d", idx, k), 32'(mem_addr), 32'(v.exp_addr));
            check($sformatf("v%0d busy c%0d", idx, k), 32'(fetch_busy), 32'd1);
            check($sformatf("v%0d done c%0d", idx, k), 32'(fetch_done), 32'd0);
            if (k == v.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        check($sformatf("v%0d done", idx), 32'(fetch_done), 32'd1);
        check($sformatf("v%0d mem_rd in DONE", idx), 32'(mem_rd), 32'd0);
        check($sformatf("v%0d ir", idx), 32'(ir), 32'(v.rdata));
        check($sformatf("v%0d opcode", idx), 32'(opcode), 32'(v.exp_op));
        check($sformatf("v%0d pc", idx), 32'(pc), 32'(v.exp_pc));
        @(negedge clk);
        check($sformatf("v%0d done low", idx), 32'(fetch_done), 32'd0);
        check($sformatf("v%0d busy low", idx), 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        //            jmp   target    rdata     dly addr      op     pc
        vecs[0] = '{1'b0, 13'h0000, 16'hA123, 1,  13'h0000, 4'hA, 13'h0001};
        vecs[1] = '{1'b0, 13'h0000, 16'h5B00, 5,  13'h0001, 4'h5, 13'h0002};
        vecs[2] = '{1'b1, 13'h0100, 16'h3C3C, 1,  13'h0100, 4'h3, 13'h0101};
        vecs[3] = '{1'b1, 13'h1FFF, 16'hF00F, 2,  13'h1FFF, 4'hF, 13'h0000};
        vecs[4] = '{1'b0, 13'h0000, 16'h0001, 1,  13'h0000, 4'h0, 13'h0001};
        vecs[5] = '{1'b0, 13'h0000, 16'h9FFF, 15, 13'h0001, 4'h9, 13'h0002};

        rst         = 1'b1;
        fetch_req   = 1'b0;
        jump_en     = 1'b0;
        jump_target = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;

        #2;
        check("reset pc", 32'(pc), 32'd0);
        check("reset ir", 32'(ir), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset done", 32'(fetch_done), 32'd0);
        check("reset busy", 32'(fetch_busy), 32'd0);
        check("reset err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Jumps during READ: the second overwrites the first, and the
        // pending target replaces the incremented pc on return to IDLE.
        // A fetch_req during DONE must not start another fetch.
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("jr addr", 32'(mem_addr), 32'h0002);
        jump_en     = 1'b1;
        jump_target = 13'h0200;
        @(negedge clk);
        check("jr mem_rd c2", 32'(mem_rd), 32'd1);
        jump_target = 13'h0300;
        mem_ack     = 1'b1;
        mem_rdata   = 16'h1111;
        @(negedge clk);
        jump_en   = 1'b0;
        mem_ack   = 1'b0;
        check("jr done", 32'(fetch_done), 32'd1);
        check("jr pc in DONE", 32'(pc), 32'h0003);
        check("jr ir", 32'(ir), 32'h1111);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("jr pc idle", 32'(pc), 32'h0300);
        check("req in DONE ignored rd", 32'(mem_rd), 32'd0);
        check("req in DONE ignored busy", 32'(fetch_busy), 32'd0);
        @(negedge clk);
        check("no queued fetch", 32'(mem_rd), 32'd0);

        // Plain jump in IDLE.
        jump_en     = 1'b1;
        jump_target = 13'h0050;
        @(negedge clk);
        jump_en = 1'b0;
        check("idle jump pc", 32'(pc), 32'h0050);
        check("idle jump busy", 32'(fetch_busy), 32'd0);

        // Ack while idle is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle ack ir", 32'(ir), 32'h1111);
        check("idle ack done", 32'(fetch_done), 32'd0);
        check("idle ack pc", 32'(pc), 32'h0050);

        // Timeout: 15 READ cycles with no ack, then ERR forever.
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int k = 1; k <= FETCH_TIMEOUT; k++) begin
            check($sformatf("to mem_rd c%0d", k), 32'(mem_rd), 32'd1);
            check($sformatf("to addr c%0d", k), 32'(mem_addr), 32'h0050);
            check($sformatf("to err c%0d", k), 32'(fetch_err), 32'd0);
            @(negedge clk);
        end
        check("to err", 32'(fetch_err), 32'd1);
        check("to mem_rd", 32'(mem_rd), 32'd0);
        check("to busy", 32'(fetch_busy), 32'd0);
        check("to pc", 32'(pc), 32'h0050);
        check("to ir", 32'(ir), 32'h1111);
        fetch_req   = 1'b1;
        jump_en     = 1'b1;
        jump_target = 13'h0777;
        mem_ack     = 1'b1;
        mem_rdata   = 16'h4321;
        @(negedge clk);
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        check("err sticky", 32'(fetch_err), 32'd1);
        check("err mem_rd", 32'(mem_rd), 32'd0);
        check("err pc", 32'(pc), 32'h0050);
        check("err ir", 32'(ir), 32'h1111);
        check("err done", 32'(fetch_done), 32'd0);

        // Asynchronous reset clears everything without a clock edge.
        rst = 1'b1;
        #1;
        check("rst err", 32'(fetch_err), 32'd0);
        check("rst pc", 32'(pc), 32'd0);
        check("rst ir", 32'(ir), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-READ, then a late ack after release.
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("mr mem_rd before rst", 32'(mem_rd), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr mem_rd async", 32'(mem_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("mr ir", 32'(ir), 32'd0);
        check("mr done", 32'(fetch_done), 32'd0);
        check("mr pc", 32'(pc), 32'd0);
        check("mr mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        check("mr done later", 32'(fetch_done), 32'd0);
        check("mr ir later", 32'(ir), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 fetch_req  in  1  controller request to fetch next instruction; single-cycle pulse.
REQ-004 fetch_done  out  1  one-cycle pulse: ir/opcode valid with the new instruction.
REQ-005 fetch_busy  out  1  high from request acceptance until fetch_done or error.
REQ-006 jump_en  in  1  load PC from jump_target; single-cycle pulse.
REQ-007 jump_target  in  13  jump destination word address.
REQ-008 mem_addr  out  13  instruction memory word address.
REQ-009 mem_rd  out  1  memory read strobe; held high until mem_ack.
REQ-010 mem_ack  in  1  memory read complete; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  in  16  memory read data.
REQ-012 ir  out  16  instruction register.
REQ-013 opcode  out  4  ir[15:12]; feeds the controller instruction input.
REQ-014 pc  out  13  current program counter, the address of the next fetch.
REQ-015 fetch_err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, DONE and ERR.
REQ-017 IDLE: fetch_req=1 -> READ; mem_addr=pc and mem_rd=1 from the next cycle.
REQ-018 READ: mem_rd=1 and mem_addr=pc stable every cycle; mem_ack=1 -> ir<=mem_rdata, pc<=pc+1, state DONE.
REQ-019 DONE: fetch_done=1 for exactly one cycle -> IDLE; minimum request-to-done latency is 2 cycles (ack in first READ cycle).
REQ-020 pc increments modulo 2^13 (8191 -> 0); no carry-out flag.
REQ-021 jump_en in IDLE: pc<=jump_target next cycle.
REQ-022 jump_en together with fetch_req in IDLE: the fetch uses jump_target as its address, and pc ends at jump_target+1.
REQ-023 jump_en in READ or DONE: target latched into a one-entry pending register; applied as pc<=target on entry to IDLE, overriding the increment; a later jump while pending overwrites the earlier one.
REQ-024 fetch_req outside IDLE is ignored; no queuing.
REQ-025 A wait counter (4 bits) counts READ cycles without ack; on reaching 15, -> ERR, mem_rd=0, fetch_err=1, ir and pc unchanged.
REQ-026 ERR is left only by rst; fetch_req and jump_en are ignored in ERR; fetch_busy=0 in ERR.
REQ-027 mem_ack outside READ is ignored; mem_rd SHALL never be high outside READ.
REQ-028 fetch_busy=1 in READ and DONE, 0 in IDLE and ERR.

Reset
REQ-029 rst asserted: state IDLE, pc=0, ir=0, pending jump cleared, wait counter 0, fetch_err=0, mem_rd=0, fetch_done=0, immediately and without a clock.
REQ-030 rst during READ abandons the read; a late mem_ack after reset release is ignored per REQ-027.

Structure
REQ-031 Package cpu_pkg holds the fetch state enum, PC_W=13, INSTR_W=16, OPCODE_W=4 and FETCH_TIMEOUT=15.
REQ-032 One sub-module, pc_counter: a 13-bit register with load, increment and async reset.

Verification
REQ-033 Reset, then fetch_req with ack in the first READ cycle and rdata=16'hA123 -> fetch_done 2 cycles after the request, ir=A123, opcode=4'hA, pc=1.
REQ-034 Ack delayed 5 cycles -> mem_rd held 5 cycles with mem_addr constant; fetch_done 1 cycle after ack.
REQ-035 pc=8191, fetch completes -> pc=0.
REQ-036 jump_en(target=0x0100) together with fetch_req in IDLE -> mem_addr=0x0100, pc=0x0101 after done; jump_en(0x0200) during READ -> pc=0x0200 in IDLE.
REQ-037 No ack for 15 cycles -> fetch_err=1, mem_rd=0; further fetch_req ignored until rst.
REQ-038 rst pulsed mid-READ, then ack 1 cycle after release -> ir stays 0, fetch_done stays 0.
